// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and word-geometry helpers derived from the data width.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Geometry for the default 32-bit word; parameterised instances use the
    // helper functions below so the same rules apply at any width.
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int ADDRESS_STEP       = BYTES_PER_WORD;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Width of a byte-lane index; at least one bit so 8-bit words still
    // get a legal counter.
    function automatic int index_width(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into a word. The word output already
// contains the byte being accepted this cycle, so the caller can capture a
// complete word on the same edge that takes the final byte.
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            in_byte,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  last_byte
);

    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = index_width(DATA_WIDTH);

    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] lanes_q;

    // Merge the incoming byte into its lane and flag the word's final byte.
    always_comb begin
        word      = lanes_q;
        last_byte = 1'b0;
        if (accept) begin
            word[{idx_q, 3'b000} +: 8] = in_byte;
            last_byte = (idx_q == IDX_W'(BPW - 1));
        end
    end

    // Byte index and lane storage; clear drops any partial word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else if (clear) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else if (accept) begin
            lanes_q <= word;
            idx_q   <= last_byte ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer. Collects DATA_WIDTH/8 bytes per
// word over a valid/ready handshake and writes each word to consecutive
// aligned byte addresses, wrapping at the top of the address space.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// COLLECT | in_ready high, accepting bytes of the current word
// WRITE   | one-cycle wr_en strobe for the assembled word
// DONE    | one-cycle done pulse, then back to IDLE
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_WIDTH-1:0] word_count,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int                     BPW       = bytes_per_word(DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BPW);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(BPW - 1);

    state_t state, next_state;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] remaining_q;
    logic                     asm_clear;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    asm_word;
    logic                     last_byte;

    // in_ready is a flop, so acceptance never depends combinationally on
    // in_valid feeding back into in_ready.
    assign accept = in_valid && in_ready;

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .accept    (accept),
        .in_byte   (in_data),
        .word      (asm_word),
        .last_byte (last_byte)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and byte-index clear requests.
    always_comb begin
        next_state = state;
        asm_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    asm_clear  = 1'b1;
                    next_state = (word_count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                asm_clear  = 1'b1;
                next_state = (remaining_q == ADDRESS_WIDTH'(1)) ? DONE : COLLECT;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address and remaining-word bookkeeping; wr_address/wr_data are loaded
    // only when a word completes so they hold steady between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
            wr_address  <= '0;
            wr_data     <= '0;
        end else begin
            if (state == IDLE && start) begin
                addr_q      <= base_address & ALIGN_MASK;
                remaining_q <= word_count;
            end
            if (state == WRITE) begin
                addr_q      <= addr_q + ADDR_STEP;
                remaining_q <= remaining_q - ADDRESS_WIDTH'(1);
            end
            if (last_byte) begin
                wr_address <= addr_q;
                wr_data    <= asm_word;
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (next_state == COLLECT);
            wr_en    <= (next_state == WRITE);
            busy     <= (next_state != IDLE);
            done     <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// loads, checked against a queue of expected (address, word) writes.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  base_address;
    logic [7:0]  word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_address;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    imem_loader #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_address (base_address),
        .word_count   (word_count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    wr_t         expq[$];
    int          wr_cyc[$];
    logic [7:0]  stream[$];
    logic        ready_ever;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_addr(input logic [7:0] base, input int k);
        return 8'(int'(base & 8'hFC) + 4 * k);
    endfunction

    function automatic logic [31:0] model_word(input int k);
        return {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
    endfunction

    always @(posedge clock) cyc++;

    // Compare every write against the model, and every done against an
    // empty expectation queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en) begin
                wr_cyc.push_back(cyc);
                chk("ready_in_write", in_ready, 0);
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wr_address, wr_data);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    chk("wr_address", wr_address, e.a);
                    chk("wr_data", wr_data, e.d);
                end
            end
            if (done) chk("done_all_written", expq.size(), 0);
        end
    end

    // vmode: 0 valid held high, 1 toggle every cycle, 2 random.
    task automatic do_load(input logic [7:0] base, input logic [7:0] cnt,
                           input int vmode, input int restart_at);
        int  n;
        int  i;
        int  guard;
        logic v;
        logic tog;
        logic ready_seen;
        logic restarted;
        n = 4 * int'(cnt);
        wr_cyc.delete();
        for (int k = 0; k < int'(cnt); k++) begin
            wr_t e;
            e.a = model_addr(base, k);
            e.d = model_word(k);
            expq.push_back(e);
        end
        ready_ever = 1'b0;
        @(negedge clock);
        base_address = base;
        word_count   = cnt;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, (cnt != 0));
        if (cnt == 0) chk("zero_done_t1", done, 1);
        ready_ever = in_ready;
        i = 0; guard = 0; tog = 1'b1; restarted = 1'b0;
        while (i < n && guard < 2000) begin
            case (vmode)
                0: v = 1'b1;
                1: begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid   = v;
            in_data    = stream[i];
            ready_seen = in_ready;
            if (i == restart_at && !restarted) begin
                restarted    = 1'b1;
                start        = 1'b1;
                word_count   = 8'd7;
                base_address = 8'h80;
            end
            @(negedge clock);
            start = 1'b0;
            ready_ever = ready_ever | in_ready;
            if (v && ready_seen) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (i < n) begin
            checks++;
            fails++;
            $display("FAIL byte_feed_timeout: got %0d bytes accepted, expected %0d", i, n);
        end
        guard = 0;
        while (!done && guard < 300) begin
            @(negedge clock);
            ready_ever = ready_ever | in_ready;
            guard++;
        end
        chk("done_seen", done, 1);
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("write_count", wr_cyc.size(), cnt);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_address = '0;
        word_count   = '0;
        in_data      = '0;
        in_valid     = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {in_ready, wr_en, wr_address, wr_data, busy, done}, 0);
        reset = 1'b0;

        // Basic load with literal pins on the model.
        stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        chk("model_pin_w0", model_word(0), 32'h00000013);
        chk("model_pin_w1", model_word(1), 32'h00100093);
        chk("model_pin_a1", model_addr(8'h00, 1), 8'h04);
        do_load(8'h00, 8'd2, 0, -1);
        if (wr_cyc.size() == 2) chk("basic_gap", wr_cyc[1] - wr_cyc[0], 5);
        else begin
            checks++; fails++;
            $display("FAIL basic_gap: got %0d writes, expected 2", wr_cyc.size());
        end

        // Misaligned base and stalls.
        stream = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk("model_pin_align", model_addr(8'h07, 0), 8'h04);
        do_load(8'h07, 8'd1, 1, -1);

        // Wrap-around.
        stream = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        chk("model_pin_wrap", model_addr(8'hFC, 1), 8'h00);
        do_load(8'hFC, 8'd2, 0, -1);

        // Zero count.
        stream.delete();
        do_load(8'h40, 8'd0, 0, -1);
        chk("zero_no_ready", ready_ever, 0);

        // Mid-word reset: two bytes in, then reset.
        @(negedge clock);
        base_address = 8'h20; word_count = 8'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clock);
        in_data = 8'h22;
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midword_reset_outputs", {in_ready, wr_en, wr_address, wr_data, busy, done}, 0);
        expq.delete();
        @(negedge clock);
        reset = 1'b0;
        stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        chk("model_pin_stale", model_word(0), 32'hDDCCBBAA);
        do_load(8'h10, 8'd1, 0, -1);

        // Start while busy is ignored.
        stream.delete();
        for (int k = 0; k < 8; k++) stream.push_back(8'($urandom));
        do_load(8'h30, 8'd2, 0, 2);

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            logic [7:0] b;
            logic [7:0] c;
            b = 8'($urandom);
            c = 8'($urandom_range(1, 4));
            stream.delete();
            for (int k = 0; k < 4 * int'(c); k++) stream.push_back(8'($urandom));
            do_load(b, c, 2, -1);
        end

        repeat (3) @(negedge clock);
        chk("no_pending_writes", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
